thumb_prefetch_buf: RTL

Parametrised Thumb-2 prefetch and instruction-assembly unit; the next generation of the fixed halfword fetch stage.
- Issues aligned fetch requests and buffers returned halfwords in a ring.
- Assembles 16-bit and 32-bit Thumb instructions, each tagged with its PC.
- Supports branch flush, including discard of stale in-flight responses.
- Sits between instruction memory and pre-decode; its output feeds the stage-2 pipeline register.

---
 rtl/arm_core_pkg.sv | 17 +
 rtl/prefetch_hw_ring.sv | 72 +++++++
 rtl/thumb_prefetch_buf.sv | 137 +++++++++++++
 3 files changed

// File: rtl/arm_core_pkg.sv
// Shared Thumb definitions: halfword type and the 32-bit instruction prefix test.
package arm_core_pkg;

    localparam int unsigned HW_W = 16;

    // One ring entry: a single Thumb halfword.
    typedef logic [HW_W-1:0] hw_t;

    // A halfword opens a 32-bit Thumb-2 instruction when its top five bits are
    // 11101, 11110 or 11111.
    function automatic logic is_thumb32(input hw_t hw);
        hw_t top;
        top = hw >> 11;
        return (top == 16'h001D) || (top == 16'h001E) || (top == 16'h001F);
    endfunction

endpackage

// File: rtl/prefetch_hw_ring.sv
// Halfword ring buffer: multi-halfword push, 0..2 halfword pop, flush clear.
module prefetch_hw_ring
    import arm_core_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned FETCH_HW = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clear_i,
    input  logic [$clog2(FETCH_HW+1)-1:0] push_n_i,
    input  logic [FETCH_HW*HW_W-1:0]      push_data_i,
    input  logic [1:0]                    pop_n_i,
    output hw_t                           head_o,
    output hw_t                           head1_o,
    output logic [$clog2(DEPTH):0]        count_o
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned PUSH_W = $clog2(FETCH_HW + 1);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    hw_t              mem_q [DEPTH];
    hw_t              mem_d [DEPTH];

    // Next-state: write pushed halfwords lowest-first, advance pointers, clear wins.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            for (int i = 0; i < FETCH_HW; i++) begin
                if (PUSH_W'(i) < push_n_i) begin
                    mem_d[wr_ptr_q + PTR_W'(i)] = push_data_i[i*HW_W +: HW_W];
                end
            end
            // Pointers are exactly log2(DEPTH) bits, so wrap-around is free.
            wr_ptr_d = wr_ptr_q + PTR_W'(push_n_i);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop_n_i);
            count_d  = count_q + (PTR_W+1)'(push_n_i) - (PTR_W+1)'(pop_n_i);
        end
    end

    // Ring state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign head1_o = mem_q[rd_ptr_q + PTR_W'(1)];
    assign count_o = count_q;

endmodule

// File: rtl/thumb_prefetch_buf.sv
// Thumb-2 prefetch unit: credit-limited fetch, halfword ring, 16/32-bit assembly.
module thumb_prefetch_buf
    import arm_core_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned FETCH_HW = 2,
    parameter int unsigned MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     fetch_req,
    output logic [31:0]              fetch_addr,
    input  logic                     fetch_ack,
    input  logic                     fetch_rvalid,
    input  logic [16*FETCH_HW-1:0]   fetch_rdata,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [31:0]              inst,
    output logic                     inst_is32,
    output logic [31:0]              inst_pc,
    input  logic                     flush,
    input  logic [31:0]              flush_pc
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned PUSH_W = $clog2(FETCH_HW + 1);
    localparam int unsigned OUT_W  = $clog2(MAX_OUT + 1);
    localparam int unsigned SKIP_W = (FETCH_HW > 1) ? $clog2(FETCH_HW) : 1;
    localparam int unsigned BEAT_B = 2 * FETCH_HW;

    // Halfword index of a PC within its beat: leading halfwords to drop.
    function automatic logic [SKIP_W-1:0] skip_of(input logic [31:0] pc);
        return SKIP_W'((pc >> 1) & (FETCH_HW - 1));
    endfunction

    function automatic logic [31:0] beat_align(input logic [31:0] pc);
        return pc & ~(BEAT_B - 1);
    endfunction

    logic [OUT_W-1:0]          out_q, out_d;
    logic [OUT_W-1:0]          disc_q, disc_d;
    logic [SKIP_W-1:0]         skip_q, skip_d;
    logic [31:0]               addr_q, addr_d;
    logic [31:0]               pc_q, pc_d;
    hw_t                       head, head1;
    logic [PTR_W:0]            cnt;
    logic                      head32, accept, keep, pop;
    logic [PUSH_W-1:0]         push_n;
    logic [1:0]                pop_n;
    logic [FETCH_HW*HW_W-1:0]  push_data;

    prefetch_hw_ring #(
        .DEPTH    (DEPTH),
        .FETCH_HW (FETCH_HW)
    ) u_ring (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (flush),
        .push_n_i    (push_n),
        .push_data_i (push_data),
        .pop_n_i     (pop_n),
        .head_o      (head),
        .head1_o     (head1),
        .count_o     (cnt)
    );

    // Head decode, credit check and ring push/pop control.
    always_comb begin
        head32     = is_thumb32(head);
        inst_valid = ((cnt != '0) && !head32) || ((cnt >= (PTR_W+1)'(2)) && head32);
        inst_is32  = (cnt != '0) && head32;
        inst       = '0;
        if (inst_valid) begin
            inst = head32 ? {head, head1} : {16'h0000, head};
        end
        // Each outstanding beat already has ring space reserved for it.
        fetch_req = !rst && !flush && (32'(out_q) < MAX_OUT)
                    && (32'(cnt) + FETCH_HW * (32'(out_q) + 32'd1) <= DEPTH);
        accept    = fetch_req && fetch_ack;
        keep      = fetch_rvalid && (disc_q == '0) && !flush;
        push_n    = keep ? (PUSH_W'(FETCH_HW) - PUSH_W'(skip_q)) : '0;
        push_data = fetch_rdata >> {skip_q, 4'b0000};
        pop       = inst_valid && inst_ready && !flush;
        pop_n     = pop ? (head32 ? 2'd2 : 2'd1) : 2'd0;
    end

    // Counter, skip and PC next-state; flush takes priority over everything.
    always_comb begin
        out_d  = out_q + OUT_W'(accept) - OUT_W'(fetch_rvalid);
        disc_d = disc_q;
        skip_d = skip_q;
        addr_d = addr_q;
        pc_d   = pc_q;
        if (flush) begin
            // Every beat still in flight after this cycle belongs to the old stream.
            disc_d = out_q - OUT_W'(fetch_rvalid);
            skip_d = skip_of(flush_pc);
            addr_d = beat_align(flush_pc);
            pc_d   = {flush_pc[31:1], 1'b0};
        end else begin
            if (fetch_rvalid && (disc_q != '0)) begin
                disc_d = disc_q - OUT_W'(1);
            end
            if (keep) begin
                skip_d = '0;
            end
            if (accept) begin
                addr_d = addr_q + BEAT_B;
            end
            if (pop) begin
                pc_d = pc_q + (head32 ? 32'd4 : 32'd2);
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q  <= '0;
            disc_q <= '0;
            skip_q <= skip_of(RESET_PC);
            addr_q <= beat_align(RESET_PC);
            pc_q   <= RESET_PC;
        end else begin
            out_q  <= out_d;
            disc_q <= disc_d;
            skip_q <= skip_d;
            addr_q <= addr_d;
            pc_q   <= pc_d;
        end
    end

    assign fetch_addr = addr_q;
    assign inst_pc    = pc_q;

endmodule
